// File: rtl/uart_tx_sequencer.sv
// Two-requester UART transmit front end: round-robin arbitration into a small FIFO,
// then a Wishbone master that polls the UART CTL register and writes each byte to TX.
module uart_tx_sequencer #(
    parameter int unsigned FIFO_AW      = 2,
    parameter int unsigned ACK_TIMEOUT  = 16,
    parameter int unsigned GUARD_CYCLES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_req0_valid,
    input  logic [7:0]         i_req0_data,
    output logic               o_req0_ready,
    input  logic               i_req1_valid,
    input  logic [7:0]         i_req1_data,
    output logic               o_req1_ready,
    output logic               o_wb_cyc,
    output logic               o_wb_stb,
    output logic               o_wb_we,
    output logic [1:0]         o_wb_addr,
    output logic [7:0]         o_wb_data,
    input  logic               i_wb_ack,
    input  logic               i_wb_stall,
    input  logic [7:0]         i_wb_data,
    output logic [FIFO_AW:0]   o_fifo_count,
    output logic               o_busy,
    output logic               o_err
);

    localparam int unsigned DEPTH = 1 << FIFO_AW;
    localparam int unsigned CW    = FIFO_AW + 1;
    localparam int unsigned TW    = $clog2(ACK_TIMEOUT + 1);
    localparam int unsigned GW    = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES + 1) : 1;
    localparam logic [1:0]  ADDR_TX  = 2'd0;
    localparam logic [1:0]  ADDR_CTL = 2'd2;

    typedef enum logic [2:0] {
        IDLE,
        POLL_REQ,
        POLL_WAIT,
        WR_REQ,
        WR_WAIT,
        GUARD
    } state_t;

    state_t             state;
    logic               rr_last;
    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wptr;
    logic [FIFO_AW-1:0] rptr;
    logic [TW-1:0]      tmo_cnt;
    logic [GW-1:0]      guard_cnt;

    logic               not_full_c;
    logic               push0_c;
    logic               push1_c;
    logic               push_c;
    logic               pop_c;
    logic               ack_c;
    logic               tmo_c;
    logic               idle_next_c;
    logic [7:0]         push_data_c;
    logic [CW-1:0]      count_nxt_c;
    logic               ctl_unused_c;

    // Requester that was not granted last wins a tie; a lone valid requester always gets in.
    assign not_full_c   = o_fifo_count < CW'(DEPTH);
    assign o_req0_ready = !reset && not_full_c && (rr_last || !i_req1_valid);
    assign o_req1_ready = !reset && not_full_c && (!rr_last || !i_req0_valid);
    assign push0_c      = i_req0_valid && o_req0_ready;
    assign push1_c      = i_req1_valid && o_req1_ready;
    assign push_c       = push0_c || push1_c;
    assign push_data_c  = push0_c ? i_req0_data : i_req1_data;

    // Acks only count while a cycle is open, so stray acks in IDLE/GUARD are dropped.
    assign ack_c        = o_wb_cyc && i_wb_ack;
    assign pop_c        = ack_c && o_wb_we;
    assign tmo_c        = o_wb_cyc && !i_wb_ack && (tmo_cnt == TW'(ACK_TIMEOUT - 1));
    assign count_nxt_c  = o_fifo_count + CW'(push_c) - CW'(pop_c);
    assign ctl_unused_c = ^i_wb_data[7:1];

    always_comb begin
        idle_next_c = 1'b0;
        unique case (state)
            IDLE:    idle_next_c = (o_fifo_count == '0);
            GUARD:   idle_next_c = (guard_cnt <= GW'(1));
            default: begin
                if (o_wb_cyc) begin
                    if (ack_c) idle_next_c = o_wb_we ? (GUARD_CYCLES == 0) : !i_wb_data[0];
                    else       idle_next_c = tmo_c;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr         <= '0;
            rptr         <= '0;
            o_fifo_count <= '0;
            rr_last      <= 1'b1;
        end else begin
            if (push_c) begin
                wptr    <= wptr + FIFO_AW'(1);
                rr_last <= push1_c;
            end
            if (pop_c) rptr <= rptr + FIFO_AW'(1);
            o_fifo_count <= count_nxt_c;
        end
    end

    always_ff @(posedge clk) begin
        if (push_c) mem[wptr] <= push_data_c;
    end

    // Bus master: poll CTL, write TX on ready, guard gap, abort on ack timeout.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            o_wb_cyc  <= 1'b0;
            o_wb_stb  <= 1'b0;
            o_wb_we   <= 1'b0;
            o_wb_addr <= '0;
            o_wb_data <= '0;
            o_err     <= 1'b0;
            o_busy    <= 1'b0;
            tmo_cnt   <= '0;
            guard_cnt <= '0;
        end else begin
            o_err  <= 1'b0;
            o_busy <= (count_nxt_c != '0) || !idle_next_c;
            unique case (state)
                IDLE: begin
                    if (o_fifo_count != '0) begin
                        o_wb_cyc  <= 1'b1;
                        o_wb_stb  <= 1'b1;
                        o_wb_we   <= 1'b0;
                        o_wb_addr <= ADDR_CTL;
                        tmo_cnt   <= '0;
                        state     <= POLL_REQ;
                    end
                end
                GUARD: begin
                    if (guard_cnt <= GW'(1)) state <= IDLE;
                    else                     guard_cnt <= guard_cnt - GW'(1);
                end
                default: begin
                    if (state == WR_REQ && !o_wb_cyc) begin
                        // One idle bus cycle after the poll, then present the head byte.
                        o_wb_cyc  <= 1'b1;
                        o_wb_stb  <= 1'b1;
                        o_wb_we   <= 1'b1;
                        o_wb_addr <= ADDR_TX;
                        o_wb_data <= mem[rptr];
                        tmo_cnt   <= '0;
                    end else if (ack_c) begin
                        o_wb_cyc <= 1'b0;
                        o_wb_stb <= 1'b0;
                        o_wb_we  <= 1'b0;
                        if (o_wb_we) begin
                            guard_cnt <= GW'(GUARD_CYCLES);
                            state     <= (GUARD_CYCLES == 0) ? IDLE : GUARD;
                        end else begin
                            state <= i_wb_data[0] ? WR_REQ : IDLE;
                        end
                    end else if (tmo_c) begin
                        o_wb_cyc <= 1'b0;
                        o_wb_stb <= 1'b0;
                        o_wb_we  <= 1'b0;
                        o_err    <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                        if (o_wb_stb && !i_wb_stall) begin
                            o_wb_stb <= 1'b0;
                            state    <= (state == POLL_REQ) ? POLL_WAIT : WR_WAIT;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Directed bench for uart_tx_sequencer with a small Wishbone UART slave model.
module tb_uart_tx_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       v0 = 1'b0, v1 = 1'b0;
    logic [7:0] d0 = 8'h00, d1 = 8'h00;
    logic       r0, r1;
    logic       wb_cyc, wb_stb, wb_we;
    logic [1:0] wb_addr;
    logic [7:0] wb_wdata;
    logic       wb_ack = 1'b0, wb_stall = 1'b0;
    logic [7:0] wb_rdata = 8'h00;
    logic [2:0] fifo_count;
    logic       busy, err;

    uart_tx_sequencer #(.FIFO_AW(2), .ACK_TIMEOUT(16), .GUARD_CYCLES(2)) dut (
        .clk(clk), .reset(reset),
        .i_req0_valid(v0), .i_req0_data(d0), .o_req0_ready(r0),
        .i_req1_valid(v1), .i_req1_data(d1), .o_req1_ready(r1),
        .o_wb_cyc(wb_cyc), .o_wb_stb(wb_stb), .o_wb_we(wb_we),
        .o_wb_addr(wb_addr), .o_wb_data(wb_wdata),
        .i_wb_ack(wb_ack), .i_wb_stall(wb_stall), .i_wb_data(wb_rdata),
        .o_fifo_count(fifo_count), .o_busy(busy), .o_err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Slave model state: scripted CTL reads, optional dropped write acks, logs.
    logic [7:0] ctl_default = 8'h01;
    logic [7:0] ctl_script [8];
    int         ctl_len = 0, ctl_base = 0, rd_cnt = 0;
    int         wr_att_cnt = 0, wr_ack_cnt = 0, drop_until = 0;
    logic [7:0] wr_att_data [64];
    logic [7:0] wr_ack_data [64];
    logic       acc_pend = 1'b0, acc_we = 1'b0, acc_drop = 1'b0;
    logic [7:0] acc_val = 8'h00;
    int         err_cnt = 0, err_base = 0, wcyc_cnt = 0, bad_addr = 0;

    // Accept requests as seen at the upcoming edge; log write attempts.
    always @(negedge clk) begin
        acc_pend = 1'b0;
        if (!reset && wb_cyc && wb_stb && !wb_stall) begin
            acc_pend = 1'b1;
            acc_we   = wb_we;
            if ((wb_we && wb_addr != 2'd0) || (!wb_we && wb_addr != 2'd2)) bad_addr++;
            if (wb_we) begin
                acc_val  = wb_wdata;
                acc_drop = (wr_att_cnt < drop_until);
                if (wr_att_cnt < 64) wr_att_data[wr_att_cnt] = wb_wdata;
                wr_att_cnt++;
            end else begin
                acc_val  = (rd_cnt - ctl_base < ctl_len) ? ctl_script[rd_cnt - ctl_base] : ctl_default;
                acc_drop = 1'b0;
                rd_cnt++;
            end
        end
        if (err) err_cnt++;
        if (wb_cyc && wb_we && err_cnt == err_base) wcyc_cnt++;
    end

    // Ack one cycle after acceptance.
    always @(posedge clk) begin
        #1;
        if (reset || !acc_pend || acc_drop) begin
            wb_ack = 1'b0;
        end else begin
            wb_ack   = 1'b1;
            wb_rdata = acc_we ? 8'h00 : acc_val;
            if (acc_we) begin
                if (wr_ack_cnt < 64) wr_ack_data[wr_ack_cnt] = acc_val;
                wr_ack_cnt++;
            end
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        v0 = 1'b0;
        v1 = 1'b0;
        wb_stall    = 1'b0;
        ctl_default = 8'h01;
        ctl_len     = 0;
        ctl_base    = rd_cnt;
        drop_until  = wr_att_cnt;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic offer(input int n, input logic [7:0] d, input int budget, output bit ok);
        ok = 1'b0;
        if (n == 0) begin v0 = 1'b1; d0 = d; end
        else        begin v1 = 1'b1; d1 = d; end
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk); #2;
            if ((n == 0 && r0) || (n == 1 && r1)) begin
                @(posedge clk); #1;
                ok = 1'b1;
            end
        end
        if (n == 0) v0 = 1'b0;
        else        v1 = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk); #2;
            if (fifo_count == 3'd0 && !busy && !wb_cyc) ok = 1'b1;
        end
    endtask

    bit         ok;
    int         rd_base, wr_base, att_base, wcyc_base, npush, n0, n1, early;
    bit         p0, p1, found;
    logic [7:0] pushed [8];
    logic [7:0] exp_order [4];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Reset values with both requesters offering.
        reset = 1'b1;
        v0 = 1'b1;
        v1 = 1'b1;
        #12;
        check_eq("rst_cyc",   32'(wb_cyc), 0);
        check_eq("rst_stb",   32'(wb_stb), 0);
        check_eq("rst_we",    32'(wb_we), 0);
        check_eq("rst_addr",  32'(wb_addr), 0);
        check_eq("rst_data",  32'(wb_wdata), 0);
        check_eq("rst_err",   32'(err), 0);
        check_eq("rst_count", 32'(fifo_count), 0);
        check_eq("rst_busy",  32'(busy), 0);
        check_eq("rst_rdy0",  32'(r0), 0);
        check_eq("rst_rdy1",  32'(r1), 0);

        // Single byte, ready UART.
        do_reset();
        rd_base = rd_cnt; wr_base = wr_ack_cnt;
        offer(0, 8'h41, 20, ok);
        check_eq("single_push", 32'(ok), 1);
        check_eq("single_cnt_e0", 32'(fifo_count), 1);
        check_eq("single_cyc_e0", 32'(wb_cyc), 0);
        check_eq("single_busy_e0", 32'(busy), 1);
        @(posedge clk); #1;
        check_eq("single_poll_cycstb", 32'({wb_cyc, wb_stb}), 32'h3);
        check_eq("single_poll_we", 32'(wb_we), 0);
        check_eq("single_poll_addr", 32'(wb_addr), 2);
        wait_idle(100, ok);
        check_eq("single_idle", 32'(ok), 1);
        check_eq("single_polls", rd_cnt - rd_base, 1);
        check_eq("single_writes", wr_ack_cnt - wr_base, 1);
        check_eq("single_wdata", 32'(wr_ack_data[wr_base]), 32'h41);

        // Contention: alternating grants starting with requester 0.
        do_reset();
        wr_base = wr_ack_cnt;
        exp_order[0] = 8'h10; exp_order[1] = 8'h20; exp_order[2] = 8'h11; exp_order[3] = 8'h21;
        v0 = 1'b1; v1 = 1'b1; d0 = 8'h10; d1 = 8'h20;
        n0 = 0; n1 = 0; npush = 0;
        for (int i = 0; i < 100 && npush < 4; i++) begin
            @(negedge clk); #2;
            p0 = v0 && r0;
            p1 = v1 && r1;
            @(posedge clk); #1;
            if (p0 && npush < 8) begin pushed[npush] = d0; npush++; d0++; n0++; if (n0 == 2) v0 = 1'b0; end
            if (p1 && npush < 8) begin pushed[npush] = d1; npush++; d1++; n1++; if (n1 == 2) v1 = 1'b0; end
        end
        v0 = 1'b0; v1 = 1'b0;
        check_eq("cont_npush", npush, 4);
        for (int k = 0; k < 4; k++) check_eq($sformatf("cont_push%0d", k), 32'(pushed[k]), 32'(exp_order[k]));
        wait_idle(200, ok);
        check_eq("cont_idle", 32'(ok), 1);
        check_eq("cont_writes", wr_ack_cnt - wr_base, 4);
        for (int k = 0; k < 4; k++) check_eq($sformatf("cont_wr%0d", k), 32'(wr_ack_data[wr_base + k]), 32'(exp_order[k]));

        // Stalled poll holds stb until the slave accepts.
        do_reset();
        wr_base = wr_ack_cnt;
        wb_stall = 1'b1;
        offer(1, 8'h5A, 20, ok);
        repeat (6) @(negedge clk);
        #2;
        check_eq("stall_hold", 32'({wb_cyc, wb_stb, wb_we}), 32'h6);
        wb_stall = 1'b0;
        wait_idle(100, ok);
        check_eq("stall_idle", 32'(ok), 1);
        check_eq("stall_writes", wr_ack_cnt - wr_base, 1);
        check_eq("stall_wdata", 32'(wr_ack_data[wr_base]), 32'h5A);

        // UART not ready three times, then ready.
        do_reset();
        rd_base = rd_cnt; wr_base = wr_ack_cnt;
        ctl_script[0] = 8'h00; ctl_script[1] = 8'h00; ctl_script[2] = 8'h00; ctl_script[3] = 8'h01;
        ctl_len = 4;
        offer(0, 8'h55, 20, ok);
        early = 0; found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk); #2;
            if (wr_ack_cnt == wr_base && fifo_count != 3'd1) early = 1;
            if (fifo_count == 3'd0 && !busy && !wb_cyc) found = 1'b1;
        end
        check_eq("nrdy_idle", 32'(found), 1);
        check_eq("nrdy_polls", rd_cnt - rd_base, 4);
        check_eq("nrdy_writes", wr_ack_cnt - wr_base, 1);
        check_eq("nrdy_wdata", 32'(wr_ack_data[wr_base]), 32'h55);
        check_eq("nrdy_early_pop", early, 0);

        // Full FIFO while the UART reports busy.
        do_reset();
        wr_base = wr_ack_cnt;
        ctl_default = 8'h00;
        for (int k = 0; k < 4; k++) begin
            offer(0, 8'(8'h60 + k), 20, ok);
            check_eq($sformatf("full_push%0d", k), 32'(ok), 1);
        end
        offer(0, 8'h64, 20, ok);
        check_eq("full_blocked", 32'(ok), 0);
        check_eq("full_count", 32'(fifo_count), 4);
        v1 = 1'b1;
        #1;
        check_eq("full_rdy1", 32'(r1), 0);
        v1 = 1'b0;
        ctl_default = 8'h01;
        offer(0, 8'h64, 200, ok);
        check_eq("full_push4", 32'(ok), 1);
        offer(0, 8'h65, 200, ok);
        check_eq("full_push5", 32'(ok), 1);
        wait_idle(400, ok);
        check_eq("full_idle", 32'(ok), 1);
        check_eq("full_writes", wr_ack_cnt - wr_base, 6);
        for (int k = 0; k < 6; k++) check_eq($sformatf("full_wr%0d", k), 32'(wr_ack_data[wr_base + k]), 32'h60 + k);

        // Write ack timeout, then retry of the same byte.
        do_reset();
        wr_base = wr_ack_cnt; att_base = wr_att_cnt;
        drop_until = wr_att_cnt + 1;
        err_base = err_cnt; wcyc_base = wcyc_cnt;
        offer(0, 8'h77, 20, ok);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk); #2;
            if (err_cnt != err_base) found = 1'b1;
        end
        check_eq("tmo_err_seen", 32'(found), 1);
        check_eq("tmo_wait_cycles", wcyc_cnt - wcyc_base, 16);
        check_eq("tmo_count_kept", 32'(fifo_count), 1);
        wait_idle(200, ok);
        check_eq("tmo_idle", 32'(ok), 1);
        check_eq("tmo_err_pulses", err_cnt - err_base, 1);
        check_eq("tmo_attempts", wr_att_cnt - att_base, 2);
        check_eq("tmo_att0", 32'(wr_att_data[att_base]), 32'h77);
        check_eq("tmo_att1", 32'(wr_att_data[att_base + 1]), 32'h77);
        check_eq("tmo_writes", wr_ack_cnt - wr_base, 1);
        err_base = err_cnt;

        // Asynchronous reset while waiting for a write ack.
        do_reset();
        wr_base = wr_ack_cnt; att_base = wr_att_cnt;
        drop_until = wr_att_cnt + 1;
        offer(0, 8'h88, 20, ok);
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk); #2;
            if (wb_cyc && wb_we && !wb_stb) found = 1'b1;
        end
        check_eq("arst_wrwait", 32'(found), 1);
        #1 reset = 1'b1;
        #1;
        check_eq("arst_cycstb", 32'({wb_cyc, wb_stb}), 0);
        check_eq("arst_count", 32'(fifo_count), 0);
        check_eq("arst_busy", 32'(busy), 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (40) @(negedge clk);
        #2;
        check_eq("arst_no_retry", wr_att_cnt - att_base, 1);
        check_eq("arst_no_write", wr_ack_cnt - wr_base, 0);
        check_eq("arst_cyc_low", 32'(wb_cyc), 0);

        check_eq("wb_addr_ok", bad_addr, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
